// File: rtl/demux_sequencer.sv
// Break-before-make channel sequencer for the 1-of-8 echo demux.
// Define DEMUX_SEQ_REPEAT_EN for continuous sweeping until abort.
module demux_sequencer #(
  parameter int NUM_CH     = 8,
  parameter int CNT_W      = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [NUM_CH-1:0] chan_mask_i,
  input  logic [CNT_W-1:0]  samples_per_ch_i,
  input  logic              sample_valid_i,
  output logic [3:0]        choice_o,
  output logic              route_en_o,
  output logic [CNT_W-1:0]  sample_cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int PW = $clog2(NUM_CH + 1);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_ROUTE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  lim_q, lim_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [3:0]        choice_q, choice_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     set_q, set_d;
  logic              done_q, done_d;
  logic [NUM_CH-1:0] en_m;
  logic [PW:0]       hit;

  // {found, index} of the lowest enabled channel at or above from
  function automatic logic [PW:0] find_ch(
    input logic [NUM_CH-1:0] m,
    input logic [PW-1:0]     from
  );
    logic [PW:0] r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (m[k] && (k >= int'(from)))
        r = {1'b1, PW'(k)};
    return r;
  endfunction

  assign en_m = (lim_q != '0) ? mask_q : '0;
  assign hit  = find_ch(en_m, ptr_q);

`ifdef DEMUX_SEQ_REPEAT_EN
  logic [PW:0] wrap;
  assign wrap = find_ch(en_m, '0);
`endif

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    lim_d    = lim_q;
    ptr_d    = ptr_q;
    choice_d = choice_q;
    cnt_d    = cnt_q;
    set_d    = set_q;
    done_d   = 1'b0;
    if (abort_i) begin
      state_d  = S_IDLE;
      choice_d = '0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_SELECT;
            mask_d  = chan_mask_i;
            lim_d   = samples_per_ch_i;
            ptr_d   = '0;
          end
        end
        S_SELECT: begin
          if (hit[PW]) begin
            choice_d = 4'(hit[PW-1:0]) + 4'd1;
            ptr_d    = hit[PW-1:0] + 1'b1;
            cnt_d    = '0;
            set_d    = '0;
            state_d  = (SETTLE_CYC == 0) ? S_ROUTE : S_SETTLE;
`ifdef DEMUX_SEQ_REPEAT_EN
          end else if (wrap[PW]) begin
            choice_d = 4'(wrap[PW-1:0]) + 4'd1;
            ptr_d    = wrap[PW-1:0] + 1'b1;
            cnt_d    = '0;
            set_d    = '0;
            state_d  = (SETTLE_CYC == 0) ? S_ROUTE : S_SETTLE;
`endif
          end else begin
            state_d = S_DONE;
          end
        end
        S_SETTLE: begin
          if (int'(set_q) == SETTLE_CYC - 1)
            state_d = S_ROUTE;
          else
            set_d = set_q + 1'b1;
        end
        S_ROUTE: begin
          if (sample_valid_i) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == lim_q - 1'b1) begin
              state_d  = S_SELECT;
              choice_d = '0;
`ifdef DEMUX_SEQ_REPEAT_EN
              // pulse lands on the SELECT cycle that wraps
              done_d = !hit[PW];
`endif
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    done_d = done_d | (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      lim_q    <= '0;
      ptr_q    <= '0;
      choice_q <= '0;
      cnt_q    <= '0;
      set_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      lim_q    <= lim_d;
      ptr_q    <= ptr_d;
      choice_q <= choice_d;
      cnt_q    <= cnt_d;
      set_q    <= set_d;
      done_q   <= done_d;
    end
  end

  assign choice_o     = choice_q;
  assign route_en_o   = (state_q == S_ROUTE);
  assign sample_cnt_o = cnt_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = done_q;

endmodule

// File: tb/tb_demux_sequencer.sv
// Self-checking bench for demux_sequencer: vector table,
// hand sequences and randomized sweeps against a sweep-level model.
module tb_demux_sequencer;
  localparam int NUM_CH = 8;
  localparam int CNT_W  = 8;
  localparam int SC     = 2;

  logic       clk = 1'b0;
  logic       rst, start, abort, sample_valid;
  logic [7:0] chan_mask, samples_per_ch;
  logic [3:0] choice;
  logic       route_en, busy, done;
  logic [7:0] sample_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_sequencer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SETTLE_CYC(SC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .chan_mask_i(chan_mask), .samples_per_ch_i(samples_per_ch),
    .sample_valid_i(sample_valid), .choice_o(choice),
    .route_en_o(route_en), .sample_cnt_o(sample_cnt),
    .busy_o(busy), .done_o(done)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // sweep-level model: which codes get visited at all
  function automatic logic [7:0] model_seen(input logic [7:0] m,
                                            input logic [7:0] n);
    return (n == 0) ? 8'h00 : m;
  endfunction

  task automatic run_sweep(
    input  logic [7:0] m, input logic [7:0] n, input bit rnd,
    output logic [7:0] seen, output int len, output int dones,
    output int first_nz, output int bad_settle, output int bad_cnt,
    output int bad_seq
  );
    logic [3:0] cur, last;
    int settle, routed, gap;
    bit v;
    seen = '0; len = 0; dones = 0; first_nz = -1;
    bad_settle = 0; bad_cnt = 0; bad_seq = 0;
    cur = 0; last = 0; settle = 0; routed = 0; gap = 0;
    @(negedge clk);
    chan_mask = m; samples_per_ch = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chan_mask = 8'($urandom); samples_per_ch = 8'($urandom);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!busy) break;
      len++;
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sample_valid = v;
      if (done) dones++;
      if (choice != 0) begin
        if (first_nz < 0) first_nz = cyc;
        if (choice != cur) begin
          if (cur != 0 || (last != 0 && gap < 1) ||
              choice <= last || choice > NUM_CH) bad_seq++;
          cur = choice; last = choice;
          seen[choice-1] = 1'b1;
          settle = 0; routed = 0; gap = 0;
        end
        if (!route_en) begin
          if (routed != 0) bad_settle++;
          settle++;
        end else begin
          if (settle != SC) bad_settle++;
          if (sample_cnt != routed) bad_cnt++;
          if (v) routed++;
        end
      end else begin
        if (route_en) bad_seq++;
        if (cur != 0) begin
          if (routed != n || sample_cnt != n) bad_cnt++;
          cur = 0;
        end
        gap++;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("sweep_timeout", busy, 0);
  endtask

  task automatic wait_code(input logic [3:0] c, input bit need_route,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (choice == c && (!need_route || route_en)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] m;
    logic [7:0] n;
    logic [7:0] seen;
    int         len;
    int         first_nz;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seen, m, n;
    int len, dones, fnz, bs, bc, bq, cnt;
    bit ok;

    // busy cycles = SELECT + per channel (settle+samples+SELECT) + DONE
    tbl[0] = '{8'hFF, 8'd3, 8'hFF, 50, 1};
    tbl[1] = '{8'hA4, 8'd2, 8'hA4, 17, 1};
    tbl[2] = '{8'h00, 8'd5, 8'h00, 2, -1};
    tbl[3] = '{8'hFF, 8'd0, 8'h00, 2, -1};
    tbl[4] = '{8'h01, 8'd1, 8'h01, 6, 1};
    tbl[5] = '{8'h80, 8'd4, 8'h80, 9, 1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0;
    chan_mask = '0; samples_per_ch = '0;
    repeat (3) @(negedge clk);
    chk("rst_choice", choice, 0);
    chk("rst_route_en", route_en, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

`ifdef DEMUX_SEQ_REPEAT_EN
    begin
      int seqn, wraps, bad;
      logic [3:0] prev;
      @(negedge clk);
      chan_mask = 8'h03; samples_per_ch = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; sample_valid = 1'b1;
      seqn = 0; wraps = 0; bad = 0; cnt = 0; prev = 0;
      for (int i = 0; i < 60; i++) begin
        if (choice != 0 && choice != prev) begin
          if (choice != 4'((seqn % 2) + 1)) bad++;
          seqn++;
        end
        if (choice == 0 && prev == 2) wraps++;
        if (done) cnt++;
        prev = choice;
        @(negedge clk);
      end
      chk("rep_order", bad, 0);
      chk("rep_done_per_wrap", cnt, wraps);
      chk("rep_many_wraps", wraps >= 5, 1);
      chk("rep_busy", busy, 1);
      abort = 1'b1; sample_valid = 1'b0;
      @(negedge clk);
      abort = 1'b0;
      chk("rep_abort_busy", busy, 0);
      run_sweep(8'h00, 8'd3, 1'b0, seen, len, dones, fnz, bs, bc, bq);
      chk("rep_empty_done", dones, 1);
      chk("rep_empty_len", len, 2);
    end
`else
    foreach (tbl[i]) begin
      run_sweep(tbl[i].m, tbl[i].n, 1'b0, seen, len, dones, fnz,
                bs, bc, bq);
      chk($sformatf("vec%0d_codes", i), seen, tbl[i].seen);
      chk($sformatf("vec%0d_len", i), len, tbl[i].len);
      chk($sformatf("vec%0d_done", i), dones, 1);
      chk($sformatf("vec%0d_first", i), fnz, tbl[i].first_nz);
      chk($sformatf("vec%0d_settle", i), bs, 0);
      chk($sformatf("vec%0d_cnt", i), bc, 0);
      chk($sformatf("vec%0d_seq", i), bq, 0);
    end

    // abort on code 4 after one sample
    @(negedge clk);
    chan_mask = 8'hFF; samples_per_ch = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sample_valid = 1'b1;
    wait_code(4'd4, 1'b1, ok);
    chk("abort_reach", ok, 1);
    chk("abort_cnt0", sample_cnt, 0);
    @(negedge clk);
    chk("abort_cnt1", sample_cnt, 1);
    abort = 1'b1; sample_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_choice", choice, 0);
    chk("abort_route", route_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_scnt", sample_cnt, 0);
    cnt = 0;
    repeat (20) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    chk("abort_quiet", cnt, 0);
    run_sweep(8'hFF, 8'd3, 1'b0, seen, len, dones, fnz, bs, bc, bq);
    chk("restart_codes", seen, 8'hFF);
    chk("restart_seq", bq, 0);
    chk("restart_len", len, 50);

    // abort and start together in IDLE
    start = 1'b1; abort = 1'b1; chan_mask = 8'hFF; samples_per_ch = 8'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", busy, 0);
    @(negedge clk);
    chk("abort_start_idle2", busy, 0);

    // abort with the terminal sample
    chan_mask = 8'h01; samples_per_ch = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_code(4'd1, 1'b1, ok);
    chk("term_reach", ok, 1);
    sample_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0; abort = 1'b0;
    chk("term_abort_busy", busy, 0);
    chk("term_abort_choice", choice, 0);
    cnt = 0;
    repeat (6) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("term_abort_nodone", cnt, 0);

    // strobes during SETTLE, start during ROUTE
    chan_mask = 8'h01; samples_per_ch = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; sample_valid = 1'b1;
    wait_code(4'd1, 1'b1, ok);
    chk("settle_reach", ok, 1);
    chk("settle_ignored", sample_cnt, 0);
    start = 1'b1; chan_mask = 8'hFF;
    @(negedge clk);
    start = 1'b0; sample_valid = 1'b0;
    chk("busy_start_cnt", sample_cnt, 1);
    @(negedge clk);
    chk("busy_start_choice", choice, 1);
    chk("busy_start_cnt2", sample_cnt, 1);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("last_choice0", choice, 0);
    chk("last_cnt", sample_cnt, 2);
    @(negedge clk);
    chk("last_done", done, 1);
    @(negedge clk);
    chk("last_idle", busy, 0);
    chk("last_done_drop", done, 0);
    @(negedge clk);
    chk("no_restart", busy, 0);

    // randomized sweeps against the sweep-level model
    for (int r = 0; r < 25; r++) begin
      m = 8'($urandom);
      n = 8'($urandom_range(0, 4));
      if (r % 5 == 0) m = 8'h00;
      run_sweep(m, n, 1'b1, seen, len, dones, fnz, bs, bc, bq);
      chk($sformatf("rnd%0d_codes", r), seen, model_seen(m, n));
      chk($sformatf("rnd%0d_done", r), dones, 1);
      chk($sformatf("rnd%0d_err", r), bs + bc + bq, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
